// File: rtl/fetch_queue.sv
// fetch_queue
//
// Instruction-fetch front end with a DEPTH-entry prefetch queue. It issues
// sequential word addresses to instruction memory and buffers each returned
// {instruction, pc} pair. The oldest pair is offered to decode through a
// valid/ready handshake. A taken branch empties the queue and redirects
// fetch to the branch target.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   imem_addr     fetch address (always equal to the internal fetch pc)
//   imem_instr    instruction at imem_addr, valid when imem_stall=0
//   imem_stall    memory cannot deliver imem_instr this cycle
//   branch_taken  redirect request from execute
//   new_pc        redirect target, used only when branch_taken=1
//   out_ready     decode accepts the head entry this cycle
//   out_valid     queue holds at least one entry
//   instruction   head instruction, or NOP when empty
//   prog_counter  head pc, or the fetch pc when empty
//   instr_stall   inverse of out_valid
//   occupancy     number of entries currently held

module fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter logic [XLEN-1:0]  NOP      = 32'h21000000
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic [XLEN-1:0]           imem_addr,
  input  logic [XLEN-1:0]           imem_instr,
  input  logic                      imem_stall,
  input  logic                      branch_taken,
  input  logic [XLEN-1:0]           new_pc,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [XLEN-1:0]           instruction,
  output logic [XLEN-1:0]           prog_counter,
  output logic                      instr_stall,
  output logic [$clog2(DEPTH):0]    occupancy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Entry storage. Contents need no reset: the count gates every read.
  logic [XLEN-1:0] instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];

  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] fetch_pc;

  logic has_data;
  logic pop;
  logic push;

  assign has_data = (count != '0);

  // A branch suppresses both queue operations. A full queue may still
  // accept a push when the head leaves in the same cycle.
  assign pop  = has_data & out_ready & ~branch_taken;
  assign push = ~branch_taken & ~imem_stall & ((count < DEPTH_C) | pop);

  // Pointer, count and fetch-pc state. The pointers are exactly PW bits
  // wide, so they wrap modulo DEPTH without explicit handling.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
    end else if (branch_taken) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= new_pc;
    end else begin
      if (push) begin
        tail     <= tail + PW'(1);
        fetch_pc <= fetch_pc + XLEN'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Write the fetched pair at the tail slot.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_q[tail] <= imem_instr;
      pc_q[tail]    <= fetch_pc;
    end
  end

  // Outputs come only from registers and the head-indexed mux. When the
  // queue is empty, prog_counter shows the address being fetched.
  assign imem_addr    = fetch_pc;
  assign out_valid    = has_data;
  assign instr_stall  = ~has_data;
  assign instruction  = has_data ? instr_q[head] : NOP;
  assign prog_counter = has_data ? pc_q[head] : fetch_pc;
  assign occupancy    = count;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//
// Testbench for fetch_queue (DEPTH=4, XLEN=32, RESET_PC=0). A behavioural
// memory answers every fetch address. A queue-based reference model
// predicts the outputs of the design. Directed scenario tasks are followed
// by a randomized run.

module tb_fetch_queue;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h21000000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        imem_stall;
  logic        branch_taken;
  logic [31:0] new_pc;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] instruction;
  logic [31:0] prog_counter;
  logic        instr_stall;
  logic [2:0]  occupancy;

  int          total = 0;
  int          bad   = 0;
  int          mem_mode = 0;

  entry_t      model_q[$];
  logic [31:0] model_pc;

  fetch_queue #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .imem_stall(imem_stall),
    .branch_taken(branch_taken), .new_pc(new_pc), .out_ready(out_ready),
    .out_valid(out_valid), .instruction(instruction), .prog_counter(prog_counter),
    .instr_stall(instr_stall), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  // Instruction memory contents: an easy-to-read pattern or a scrambled one.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input int mode);
    if (mode == 0) return 32'h100 + a;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  always_comb imem_instr = mem_word(imem_addr, mem_mode);

  // Model expectations.
  function automatic logic exp_valid();
    return model_q.size() != 0;
  endfunction

  function automatic logic [31:0] exp_instr();
    return exp_valid() ? model_q[0].instr : NOP;
  endfunction

  function automatic logic [31:0] exp_pc();
    return exp_valid() ? model_q[0].pc : model_pc;
  endfunction

  function automatic logic [2:0] exp_occ();
    return 3'(model_q.size());
  endfunction

  // Drive one cycle of inputs, advance the model by the queue rules, and
  // return 1 time unit after the clock edge.
  task automatic step(input logic br, input logic [31:0] npc,
                      input logic stall, input logic rdy);
    bit     do_pop;
    bit     do_push;
    entry_t e;
    branch_taken = br;
    new_pc       = npc;
    imem_stall   = stall;
    out_ready    = rdy;
    if (br) begin
      model_q.delete();
      model_pc = npc;
    end else begin
      do_pop  = (model_q.size() != 0) && rdy;
      do_push = !stall && ((model_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.instr = mem_word(model_pc, mem_mode);
        e.pc    = model_pc;
        model_q.push_back(e);
        model_pc = model_pc + 32'd1;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset        = 1'b1;
    branch_taken = 1'b0;
    imem_stall   = 1'b0;
    out_ready    = 1'b0;
    new_pc       = '0;
    model_q.delete();
    model_pc     = RESET_PC;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    branch_taken = 1'b0;
    imem_stall   = 1'b0;
    out_ready    = 1'b1;
    new_pc       = '0;
    #2;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (instr_stall !== 1'b1) begin bad++; $display("FAIL reset_stall: got %b want 1", instr_stall); end
    total++; if (instruction !== NOP) begin bad++; $display("FAIL reset_instr: got %h want %h", instruction, NOP); end
    total++; if (prog_counter !== RESET_PC) begin bad++; $display("FAIL reset_pc: got %h want %h", prog_counter, RESET_PC); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_fill();
    mem_mode = 0;
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fill_valid c%0d: got %b want 1", i, out_valid); end
      total++; if (instruction !== 32'h100 + 32'(i)) begin bad++; $display("FAIL fill_instr c%0d: got %h want %h", i, instruction, 32'h100 + 32'(i)); end
      total++; if (prog_counter !== 32'(i)) begin bad++; $display("FAIL fill_pc c%0d: got %h want %h", i, prog_counter, 32'(i)); end
      total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL fill_occ c%0d: got %0d want 1", i, occupancy); end
    end
  endtask

  task automatic test_backpressure();
    int want;
    mem_mode = 0;
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      want = (i + 1 > DEPTH) ? DEPTH : i + 1;
      total++; if (occupancy !== 3'(want)) begin bad++; $display("FAIL bp_occ c%0d: got %0d want %0d", i, occupancy, want); end
      total++; if (imem_addr !== 32'(want)) begin bad++; $display("FAIL bp_addr c%0d: got %h want %h", i, imem_addr, 32'(want)); end
      total++; if (prog_counter !== 32'h0) begin bad++; $display("FAIL bp_head c%0d: got %h want 0", i, prog_counter); end
    end
    // Drain while full: every cycle pops and pushes, so no bubble appears.
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid c%0d: got %b want 1", i, out_valid); end
      total++; if (prog_counter !== 32'(i)) begin bad++; $display("FAIL full_pc c%0d: got %h want %h", i, prog_counter, 32'(i)); end
      step(1'b0, '0, 1'b0, 1'b1);
      total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ c%0d: got %0d want 4", i, occupancy); end
    end
  endtask

  task automatic test_stall();
    mem_mode = 0;
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b1);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_valid c%0d: got %b want 0", i, out_valid); end
      total++; if (instruction !== NOP) begin bad++; $display("FAIL stall_instr c%0d: got %h want %h", i, instruction, NOP); end
      total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL stall_addr c%0d: got %h want 0", i, imem_addr); end
      total++; if (instr_stall !== 1'b1) begin bad++; $display("FAIL stall_flag c%0d: got %b want 1", i, instr_stall); end
    end
    step(1'b0, '0, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL unstall_valid: got %b want 1", out_valid); end
    total++; if (prog_counter !== 32'h0) begin bad++; $display("FAIL unstall_pc: got %h want 0", prog_counter); end
    total++; if (instruction !== 32'h100) begin bad++; $display("FAIL unstall_instr: got %h want 100", instruction); end
  endtask

  task automatic test_branch();
    mem_mode = 0;
    reset_dut();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL br_pre_occ: got %0d want 3", occupancy); end
    step(1'b1, 32'h40, 1'b0, 1'b1);
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL br_occ: got %0d want 0", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL br_valid: got %b want 0", out_valid); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL br_addr: got %h want 40", imem_addr); end
    total++; if (instruction !== NOP) begin bad++; $display("FAIL br_instr: got %h want %h", instruction, NOP); end
    step(1'b0, '0, 1'b0, 1'b1);
    total++; if (prog_counter !== 32'h40) begin bad++; $display("FAIL br_pc: got %h want 40", prog_counter); end
    total++; if (instruction !== 32'h140) begin bad++; $display("FAIL br_tgt_instr: got %h want 140", instruction); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL br_tgt_valid: got %b want 1", out_valid); end
    // Branch while memory stalls: the pending request is abandoned.
    step(1'b1, 32'h80, 1'b1, 1'b1);
    total++; if (imem_addr !== 32'h80) begin bad++; $display("FAIL brst_addr: got %h want 80", imem_addr); end
    step(1'b0, '0, 1'b1, 1'b1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL brst_valid: got %b want 0", out_valid); end
    step(1'b0, '0, 1'b0, 1'b1);
    total++; if (prog_counter !== 32'h80) begin bad++; $display("FAIL brst_pc: got %h want 80", prog_counter); end
  endtask

  task automatic test_reset_mid();
    mem_mode = 0;
    reset_dut();
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL mid_occ: got %0d want 0", occupancy); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL mid_addr: got %h want %h", imem_addr, RESET_PC); end
    total++; if (instruction !== NOP) begin bad++; $display("FAIL mid_instr: got %h want %h", instruction, NOP); end
    model_q.delete();
    model_pc = RESET_PC;
    @(posedge clock);
    #1;
    reset = 1'b0;
    step(1'b0, '0, 1'b0, 1'b1);
    total++; if (prog_counter !== RESET_PC) begin bad++; $display("FAIL mid_restart_pc: got %h want %h", prog_counter, RESET_PC); end
    total++; if (instruction !== 32'h100) begin bad++; $display("FAIL mid_restart_instr: got %h want 100", instruction); end
  endtask

  task automatic test_random();
    logic        br;
    logic        st;
    logic        rd;
    logic [31:0] npc;
    mem_mode = 1;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      br  = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) < 6);
      npc = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFE : $urandom;
      step(br, npc, st, rd);
      total++; if (out_valid !== exp_valid()) begin bad++; $display("FAIL rnd_valid c%0d: got %b want %b", i, out_valid, exp_valid()); end
      total++; if (instr_stall !== !exp_valid()) begin bad++; $display("FAIL rnd_stall c%0d: got %b want %b", i, instr_stall, !exp_valid()); end
      total++; if (instruction !== exp_instr()) begin bad++; $display("FAIL rnd_instr c%0d: got %h want %h", i, instruction, exp_instr()); end
      total++; if (prog_counter !== exp_pc()) begin bad++; $display("FAIL rnd_pc c%0d: got %h want %h", i, prog_counter, exp_pc()); end
      total++; if (imem_addr !== model_pc) begin bad++; $display("FAIL rnd_addr c%0d: got %h want %h", i, imem_addr, model_pc); end
      total++; if (occupancy !== exp_occ()) begin bad++; $display("FAIL rnd_occ c%0d: got %0d want %0d", i, occupancy, exp_occ()); end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_backpressure();
    test_stall();
    test_branch();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
